// File: rtl/dist_req_scheduler_pkg.sv
// dist_sched_pkg: shared state encoding, float constants and operand widths for the distance scheduler.
package dist_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_e;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam int POINT_W = 96;
  localparam int REQ_W = 192;
endpackage

// File: rtl/dist_req_scheduler_if.sv
// dist_req_scheduler_if: requester, datapath and result signals of the distance scheduler.
interface dist_req_scheduler_if import dist_sched_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
) ();
  logic [N_REQ-1:0] req_stb;
  logic [N_REQ*REQ_W-1:0] req_pts;
  logic [N_REQ-1:0] req_ack;
  logic [POINT_W-1:0] du_a;
  logic [POINT_W-1:0] du_b;
  logic du_rst;
  logic du_rdy;
  logic [31:0] du_res;
  logic res_stb;
  logic [31:0] res_data;
  logic [TAG_W-1:0] res_tag;
  logic res_err;
  logic res_ack;
  logic busy;
  modport slave (
    input req_stb, req_pts, du_rdy, du_res, res_ack,
    output req_ack, du_a, du_b, du_rst, res_stb, res_data, res_tag, res_err, busy
  );
  modport master (
    output req_stb, req_pts, du_rdy, du_res, res_ack,
    input req_ack, du_a, du_b, du_rst, res_stb, res_data, res_tag, res_err, busy
  );
endinterface

// File: rtl/dist_req_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);
  logic [N-1:0] rot;
  always_comb begin
    rot = N'({req_i, req_i} >> ptr_i);
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) idx_o = W'((int'(ptr_i) + k) % N);
    gnt_o = N'(|req_i) << idx_o;
  end
endmodule

// File: rtl/dist_req_scheduler.sv
// dist_req_scheduler: round-robin sharing of one point-distance datapath with a watchdog abort.
module dist_req_scheduler import dist_sched_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2,
  parameter int TIMEOUT_CYC = 1023,
  parameter int START_CYC = 2
) (
  input logic CLK,
  input logic RST,
  dist_req_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2((TIMEOUT_CYC > START_CYC ? TIMEOUT_CYC : START_CYC) + 1);
  state_e state_q, state_d;
  logic [TAG_W-1:0] ptr_q, ptr_d, tag_q, tag_d, win;
  logic [N_REQ-1:0] gnt, ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POINT_W-1:0] a_q, a_d, b_q, b_d;
  logic [31:0] data_q, data_d;
  logic err_q, err_d;
  logic [REQ_W-1:0] win_pts;
  rr_arbiter #(.N(N_REQ), .W(TAG_W)) u_arb (
    .req_i(bus.req_stb),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(win)
  );
  assign win_pts = bus.req_pts[int'(win)*REQ_W +: REQ_W];
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    tag_d = tag_q;
    ack_d = '0;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (|bus.req_stb) begin
        state_d = START;
        ack_d = gnt;
        a_d = win_pts[REQ_W-1 -: POINT_W];
        b_d = win_pts[POINT_W-1:0];
        tag_d = win;
        ptr_d = (win == TAG_W'(N_REQ - 1)) ? '0 : win + 1'b1;
        cnt_d = '0;
      end
      START: begin
        state_d = (cnt_q == CNT_W'(START_CYC - 1)) ? WAIT : START;
        cnt_d = (cnt_q == CNT_W'(START_CYC - 1)) ? '0 : cnt_q + 1'b1;
      end
      // a done level and an expiring watchdog on the same cycle resolve as success
      WAIT: if (bus.du_rdy) begin
        state_d = HOLD;
        data_d = bus.du_res;
        err_d = 1'b0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
        state_d = HOLD;
        data_d = FP_QNAN;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      HOLD: state_d = bus.res_ack ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q <= '0;
      tag_q <= '0;
      ack_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      tag_q <= tag_d;
      ack_q <= ack_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
  assign bus.req_ack = ack_q;
  assign bus.du_a = a_q;
  assign bus.du_b = b_q;
  assign bus.du_rst = state_q != WAIT;
  assign bus.res_stb = state_q == HOLD;
  assign bus.res_data = data_q;
  assign bus.res_tag = tag_q;
  assign bus.res_err = err_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_dist_req_scheduler.sv
// tb_dist_req_scheduler: job-level reference model of arbitration, timing and results against the scheduler.
module tb_dist_req_scheduler;
  import dist_sched_pkg::*;
  localparam int N = 4;
  localparam int TW = 2;
  localparam int TO = 30;
  localparam int SC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dist_req_scheduler_if #(.N_REQ(N), .TAG_W(TW)) bus ();
  dist_req_scheduler #(.N_REQ(N), .TAG_W(TW), .TIMEOUT_CYC(TO), .START_CYC(SC)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );
  logic [REQ_W-1:0] pts [N];
  int checks = 0;
  int errors = 0;
  int ptr_m = 0;
  int dp_lat = 0;
  int low_cnt = 0;
  bit stale = 1'b0;
  bit noise = 1'b0;
  function automatic logic [31:0] dp_fn(input logic [95:0] a, input logic [95:0] b);
    if ({a, b} == {32'h40400000, 32'h40800000, 32'h0, 96'h0}) return 32'h40A00000;
    if ({a, b} == {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40C00000, 32'h40400000})
      return 32'h40A00000;
    return a[31:0] ^ {b[15:0], b[95:80]} ^ 32'h3C000000;
  endfunction
  always_comb for (int i = 0; i < N; i++) bus.req_pts[i*REQ_W +: REQ_W] = pts[i];
  // datapath model: done level rises on the dp_lat-th cycle of du_rst low; dp_lat 0 never finishes
  always @(posedge clk) low_cnt <= bus.du_rst ? 0 : low_cnt + 1;
  assign bus.du_rdy = stale || (!bus.du_rst && dp_lat > 0 && low_cnt >= dp_lat - 1);
  assign bus.du_res = dp_fn(bus.du_a, bus.du_b);
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
  endtask
  task automatic run_job(input logic [N-1:0] stb, input int lat, input int hold_cyc, input bit keep);
    int w, k, low, wcyc;
    bit exp_e;
    logic [31:0] exp_d;
    w = 0;
    for (int i = N - 1; i >= 0; i--)
      if (((stb >> ((ptr_m + i) % N)) & N'(1)) != 0) w = (ptr_m + i) % N;
    exp_e = lat <= 0 || lat > TO + 1;
    wcyc = exp_e ? TO + 1 : lat;
    exp_d = exp_e ? FP_QNAN : dp_fn(pts[w][191:96], pts[w][95:0]);
    dp_lat = lat;
    bus.req_stb = stb;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.req_ack == '0 && k < 5);
    chk("grant_wait", 96'(k), 96'(1));
    chk("req_ack", 96'(bus.req_ack), 96'(N'(1) << w));
    chk("du_a", bus.du_a, pts[w][191:96]);
    chk("du_b", bus.du_b, pts[w][95:0]);
    if (!keep) bus.req_stb = stb & ~(N'(1) << w);
    k = 0;
    low = 0;
    do begin
      @(negedge clk);
      k++;
      low += int'(!bus.du_rst);
      chk("ack_while_busy", 96'(bus.req_ack), 96'(0));
      bus.res_ack = noise && !bus.res_stb && ($urandom_range(0, 1) == 1);
    end while (!bus.res_stb && k < SC + TO + 10);
    bus.res_ack = 1'b0;
    chk("res_latency", 96'(k), 96'(SC + wcyc));
    chk("du_rst_low", 96'(low), 96'(wcyc));
    chk("res_data", 96'(bus.res_data), 96'(exp_d));
    chk("res_tag", 96'(bus.res_tag), 96'(w));
    chk("res_err", 96'(bus.res_err), 96'(exp_e));
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      chk("hold_stb", 96'(bus.res_stb), 96'(1));
      chk("hold_data", 96'(bus.res_data), 96'(exp_d));
      chk("hold_tag", 96'(bus.res_tag), 96'(w));
      chk("hold_ack", 96'(bus.req_ack), 96'(0));
    end
    bus.res_ack = 1'b1;
    @(negedge clk);
    bus.res_ack = 1'b0;
    chk("post_stb", 96'(bus.res_stb), 96'(0));
    chk("post_busy", 96'(bus.busy), 96'(0));
    ptr_m = (w + 1) % N;
  endtask
  initial begin
    int k;
    bus.req_stb = '0;
    bus.res_ack = 1'b0;
    for (int i = 0; i < N; i++) pts[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 96'(bus.req_ack), 96'(0));
    chk("rst_stb", 96'(bus.res_stb), 96'(0));
    chk("rst_err", 96'(bus.res_err), 96'(0));
    chk("rst_data", 96'(bus.res_data), 96'(0));
    chk("rst_tag", 96'(bus.res_tag), 96'(0));
    chk("rst_busy", 96'(bus.busy), 96'(0));
    chk("rst_du_rst", 96'(bus.du_rst), 96'(1));
    chk("rst_du_a", bus.du_a, 96'(0));
    chk("rst_du_b", bus.du_b, 96'(0));
    rst = 1'b0;
    pts[0] = {32'h40400000, 32'h40800000, 32'h0, 96'h0};
    run_job(4'b0001, 20, 3, 0);
    for (int i = 0; i < N; i++) pts[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_reset();
    for (int j = 0; j < 5; j++) run_job(4'b1111, 3 + j, 0, 1);
    run_job(4'b1111, 4, 50, 1);
    run_job(4'b0010, 0, 2, 0);
    run_job(4'b0100, TO + 1, 1, 0);
    run_job(4'b0100, TO + 2, 1, 0);
    do_reset();
    dp_lat = 0;
    bus.req_stb = 4'b0100;
    @(negedge clk);
    chk("mid_ack", 96'(bus.req_ack), 96'(4'b0100));
    bus.req_stb = '0;
    repeat (SC + 3) @(negedge clk);
    chk("mid_in_wait", 96'(bus.du_rst), 96'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", 96'(bus.busy), 96'(0));
    chk("mid_stb", 96'(bus.res_stb), 96'(0));
    chk("mid_du_rst", 96'(bus.du_rst), 96'(1));
    chk("mid_req_ack", 96'(bus.req_ack), 96'(0));
    ptr_m = 0;
    run_job(4'b1010, 5, 1, 0);
    pts[3] = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40C00000, 32'h40400000};
    stale = 1'b1;
    run_job(4'b1000, 1, 1, 0);
    stale = 1'b0;
    noise = 1'b1;
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < N; i++) pts[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      k = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, TO + 3);
      run_job(N'($urandom_range(1, 15)), k, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    bus.req_stb = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dist_req_scheduler.md
Name: dist_req_scheduler

Overview:
- Shares one point-distance datapath (3-lane FP subtract feeding the vector-length unit) among N requesters, e.g. sphere-pair collision checkers.
- Arbitrates round-robin and latches the winner's two points. Drives the datapath's start/reset sequencing.
- Waits for the datapath's done level, then returns the IEEE-754 single result tagged with the requester index over a stb/ack handshake.
- Provides a watchdog timeout so a hung datapath cannot deadlock the scheduler.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TAG_W, 2, requester index width; must equal clog2(N_REQ).
- TIMEOUT_CYC, 1023, cycles in WAIT before abort.
- START_CYC, 2, cycles du_rst is held high before release.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST  in  1  reset, synchronous, active-high.
- req_stb  in  N_REQ  per-requester request valid.
- req_pts  in  N_REQ*192  per-requester {a1,a2,a3,b1,b2,b3}, 32-bit floats each; requester i at bits [i*192 +: 192].
- req_ack  out  N_REQ  one-cycle grant/accept pulse to the winning requester.
- du_a  out  96  latched {a1,a2,a3} to the datapath.
- du_b  out  96  latched {b1,b2,b3} to the datapath.
- du_rst  out  1  datapath reset; high except while a job runs.
- du_rdy  in  1  datapath done level.
- du_res  in  32  datapath distance result.
- res_stb  out  1  result valid.
- res_data  out  32  distance; 0x7FC00000 on timeout.
- res_tag  out  TAG_W  index of the requester that owns the result.
- res_err  out  1  high when the result is a timeout abort.
- res_ack  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST=1 at an edge) forces, on the next cycle:
  - state IDLE; req_ack=0; res_stb=0; res_err=0; res_data=0; res_tag=0; busy=0.
  - du_rst=1; du_a=du_b=0; RR pointer=0; counters=0.
  - RST mid-job aborts the job silently; no result is returned.
- State machine:
  - IDLE: if any req_stb, grant the first set bit at or after the RR pointer (wrapping).
    - Same edge: pulse req_ack[winner] for exactly 1 cycle, latch the winner's req_pts into du_a/du_b, latch the tag, set RR pointer = winner+1 mod N_REQ, go to START.
    - No request: stay IDLE.
  - START: hold du_rst=1 for START_CYC cycles (counter from 0), then go to WAIT.
  - WAIT: du_rst=0; the watchdog counter increments each cycle.
    - du_rdy=1: latch du_res into res_data, res_err=0, go to HOLD.
    - du_rdy=0 and counter==TIMEOUT_CYC: res_data=0x7FC00000, res_err=1, go to HOLD.
    - du_rdy wins if both happen on the same cycle.
  - HOLD: res_stb=1 and du_rst=1. res_data, res_tag and res_err are stable while res_stb=1.
    - On a cycle with res_ack=1: res_stb drops the next cycle, go to IDLE.
    - res_ack seen while res_stb=0 is ignored.
- Minimum cycles from req_stb (sampled in IDLE) to res_stb: 1 + START_CYC + 1 + datapath latency.
- Throughput: one job at a time; new requests are not granted until IDLE.
  - A requester must keep req_stb and req_pts stable until it sees req_ack.
  - A requester deasserting req_stb before grant is legal; it is simply not selected.
- Arbitration boundaries:
  - Several requests at once: the lowest index at or after the pointer wins.
  - Pointer wraps from N_REQ-1 to 0.
  - A single persistent requester is re-granted on every IDLE visit.
- du_rdy while not in WAIT is ignored (stale done from the previous job).
- Operand arithmetic is pass-through. The scheduler never modifies float bits; sign negation stays in the datapath.

Decomposition:
- Shared package dist_sched_pkg holds:
  - state encoding IDLE/START/WAIT/HOLD (2 bits);
  - FP_QNAN = 32'h7FC00000;
  - POINT_W = 96 and REQ_W = 192.
- One sub-module: rr_arbiter (N_REQ requests plus pointer in; one-hot grant and encoded index out; purely combinational). The FSM, operand latches and watchdog stay in the top.

Test Plan:
- Single request: req 0 = a(3.0,4.0,0.0), b(0,0,0), datapath model latency 20. Required: req_ack[0] pulse; du_rst low 20 cycles; res_data=0x40A00000 (5.0); res_tag=0; res_err=0; held until res_ack.
- Round-robin: req_stb=4'b1111 held continuously. Required: grant order 0,1,2,3,0. Each req_ack is 1 cycle. No grant while busy=1.
- Backpressure: res_ack held 0 for 50 cycles after res_stb. Required: res_stb/data/tag stable for 50 cycles. No new req_ack. IDLE the cycle after res_ack.
- Timeout: datapath model never raises du_rdy, TIMEOUT_CYC=15. Required: res_stb after 1+START_CYC+16 cycles, res_data=0x7FC00000, res_err=1.
- Reset mid-WAIT: assert RST during WAIT of a job for req 2. Required: next cycle state IDLE, res_stb=0, du_rst=1, pointer=0. The subsequent req 1 is granted normally.
- Stale done: du_rdy held 1 from the previous job into START. Required: ignored until WAIT. The result equals the new job's du_res (points (1,2,3),(4,6,3) -> 0x40A00000).
